// File: rtl/pcie_phy_pkg.sv
// Shared symbol codes, enums and source-selection helpers for the PCIe TX lane scheduler.
package pcie_phy_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] D10_2 = 8'h4A;
  localparam logic [7:0] D5_2  = 8'h45;
  localparam logic [7:0] D0_0  = 8'h00;

  localparam logic [3:0] SKP_LAST_IDX  = 4'd3;
  localparam logic [3:0] EIOS_LAST_IDX = 4'd3;
  localparam logic [3:0] TS_LAST_IDX   = 4'd15;

  typedef enum logic [1:0] {
    OS_TS1  = 2'd0,
    OS_TS2  = 2'd1,
    OS_EIOS = 2'd2,
    OS_RSVD = 2'd3
  } os_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKP  = 2'd1,
    ST_OS   = 2'd2,
    ST_DATA = 2'd3
  } sched_state_e;

  // Source priority at a boundary: SKP beats OS, OS beats data.
  function automatic sched_state_e pick_source(input logic tx_en, input logic skp_pend,
                                               input logic os_req, input logic data_avail);
    if (!tx_en)     return ST_IDLE;
    if (skp_pend)   return ST_SKP;
    if (os_req)     return ST_OS;
    if (data_avail) return ST_DATA;
    return ST_IDLE;
  endfunction

  function automatic logic [3:0] os_last_idx(input os_type_e os_type);
    return (os_type == OS_EIOS) ? EIOS_LAST_IDX : TS_LAST_IDX;
  endfunction

endpackage

// File: rtl/pcie_tx_os_symbol.sv
// Ordered-set symbol lookup: maps set type and symbol index to the byte and K flag.
module pcie_tx_os_symbol
  import pcie_phy_pkg::*;
(
  input  os_type_e   os_type,
  input  logic [3:0] idx,
  input  logic [7:0] link_num,
  input  logic [4:0] lane_num,
  input  logic [7:0] n_fts,
  input  logic [7:0] rate_id,
  input  logic [7:0] train_ctrl,
  output logic       k,
  output logic [7:0] sym
);

  // Reserved type falls through to the TS1 filler symbol.
  always_comb begin
    k   = 1'b0;
    sym = D0_0;
    if (idx == 4'd0) begin
      k   = 1'b1;
      sym = K28_5;
    end else if (os_type == OS_EIOS) begin
      k   = 1'b1;
      sym = K28_3;
    end else begin
      case (idx)
        4'd1:    sym = link_num;
        4'd2:    sym = {3'b000, lane_num};
        4'd3:    sym = n_fts;
        4'd4:    sym = rate_id;
        4'd5:    sym = train_ctrl;
        default: sym = (os_type == OS_TS2) ? D5_2 : D10_2;
      endcase
    end
  end

endmodule

// File: rtl/pcie_tx_symbol_sched.sv
// Per-lane TX symbol scheduler: one registered byte+K per clock from SKP, LTSSM ordered sets,
// link-layer packets or logical idle, with SKP interval timing and no set/packet interleaving.
module pcie_tx_symbol_sched
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_CNT_W    = 11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_en_i,
  input  logic       os_req_i,
  input  logic [1:0] os_type_i,
  input  logic [7:0] link_num_i,
  input  logic [4:0] lane_num_i,
  input  logic [7:0] n_fts_i,
  input  logic [7:0] rate_id_i,
  input  logic [7:0] train_ctrl_i,
  output logic       os_ack_o,
  input  logic [7:0] data_i,
  input  logic       data_k_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [7:0] sym_o,
  output logic       sym_k_o,
  output logic       skp_sent_o,
  output logic       underrun_o
);

  localparam logic [SKP_CNT_W-1:0] SKP_TIMER_MAX = SKP_CNT_W'(SKP_INTERVAL - 1);
  localparam logic [SKP_CNT_W-1:0] SKP_TIMER_PRE = SKP_CNT_W'(SKP_INTERVAL - 2);

  sched_state_e state, state_next, eff_state;
  logic [3:0]   idx, idx_next, eff_idx;
  logic [SKP_CNT_W-1:0] skp_timer;
  logic         skp_pend;

  os_type_e     os_type_q;
  logic [7:0]   link_q, n_fts_q, rate_q, ctrl_q;
  logic [4:0]   lane_q;

  logic         data_done, set_done;
  logic         skp_start, os_start, ack_d, underrun_d;
  logic [7:0]   sym_d, os_sym;
  logic         k_d, os_k;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // IDLE is a free slot: the chosen source starts in the same cycle. A consumed last byte
  // still shows data_valid_i, so data cannot be re-chosen on that same cycle.
  always_comb begin
    eff_state = state;
    eff_idx   = idx;
    if (state == ST_IDLE) begin
      eff_state = pick_source(tx_en_i, skp_pend, os_req_i, data_valid_i);
      eff_idx   = '0;
    end
    data_done  = (eff_state == ST_DATA) && data_valid_i && data_last_i;
    set_done   = ((eff_state == ST_SKP) && (eff_idx == SKP_LAST_IDX)) ||
                 ((eff_state == ST_OS) && (eff_idx == os_last_idx(os_type_q))) ||
                 data_done;
    state_next = eff_state;
    idx_next   = '0;
    if (set_done)
      state_next = pick_source(tx_en_i, skp_pend, os_req_i, data_valid_i && !data_done);
    else if ((eff_state == ST_SKP) || (eff_state == ST_OS))
      idx_next = eff_idx + 4'd1;
  end

  always_comb begin
    sym_d        = D0_0;
    k_d          = 1'b0;
    skp_start    = (eff_state == ST_SKP) && (eff_idx == 4'd0);
    os_start     = (eff_state == ST_OS) && (eff_idx == 4'd0);
    ack_d        = (eff_state == ST_OS) && set_done && os_req_i;
    underrun_d   = (eff_state == ST_DATA) && !data_valid_i;
    data_ready_o = (eff_state == ST_DATA);
    case (eff_state)
      ST_SKP: begin
        sym_d = (eff_idx == 4'd0) ? K28_5 : K28_0;
        k_d   = 1'b1;
      end
      ST_OS: begin
        sym_d = os_sym;
        k_d   = os_k;
      end
      ST_DATA: begin
        if (data_valid_i) begin
          sym_d = data_i;
          k_d   = data_k_i;
        end
      end
      default: ;
    endcase
  end

  pcie_tx_os_symbol u_os_symbol (
    .os_type    (os_type_q),
    .idx        (eff_idx),
    .link_num   (link_q),
    .lane_num   (lane_q),
    .n_fts      (n_fts_q),
    .rate_id    (rate_q),
    .train_ctrl (ctrl_q),
    .k          (os_k),
    .sym        (os_sym)
  );

  // Symbol 0 is always COM, so fields captured on that cycle are in place from symbol 1 on.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      os_type_q <= OS_TS1;
      link_q    <= '0;
      lane_q    <= '0;
      n_fts_q   <= '0;
      rate_q    <= '0;
      ctrl_q    <= '0;
    end else if (os_start) begin
      os_type_q <= os_type_e'(os_type_i);
      link_q    <= link_num_i;
      lane_q    <= lane_num_i;
      n_fts_q   <= n_fts_i;
      rate_q    <= rate_id_i;
      ctrl_q    <= train_ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !tx_en_i || skp_start) begin
      skp_timer <= '0;
      skp_pend  <= 1'b0;
    end else if (skp_timer != SKP_TIMER_MAX) begin
      skp_timer <= skp_timer + 1'b1;
      if (skp_timer == SKP_TIMER_PRE)
        skp_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sym_o      <= D0_0;
      sym_k_o    <= 1'b0;
      os_ack_o   <= 1'b0;
      skp_sent_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      sym_o      <= sym_d;
      sym_k_o    <= k_d;
      os_ack_o   <= ack_d;
      skp_sent_o <= skp_start;
      underrun_o <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcie_tx_symbol_sched.sv
// Directed table-driven bench for pcie_tx_symbol_sched with a short SKP interval of 8.
module tb_pcie_tx_symbol_sched;

  localparam logic [7:0] LINK = 8'h05;
  localparam logic [4:0] LANE = 5'd3;
  localparam logic [7:0] NFTS = 8'h1F;
  localparam logic [7:0] RATE = 8'h02;
  localparam logic [7:0] CTRL = 8'h08;

  logic       clk_i = 1'b0;
  logic       rst_ni, tx_en_i, os_req_i, data_k_i, data_valid_i, data_last_i;
  logic [1:0] os_type_i;
  logic [7:0] data_i;
  logic [7:0] link_num_i, n_fts_i, rate_id_i, train_ctrl_i;
  logic [4:0] lane_num_i;
  logic       os_ack_o, data_ready_o, sym_k_o, skp_sent_o, underrun_o;
  logic [7:0] sym_o;

  typedef struct {
    logic       rst_n;
    logic       tx_en;
    logic       os_req;
    logic [1:0] os_type;
    logic [7:0] data;
    logic       data_k;
    logic       valid;
    logic       last;
    logic [7:0] sym;
    logic       k;
    logic       ack;
    logic       skp;
    logic       under;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  always #5 clk_i = ~clk_i;

  pcie_tx_symbol_sched #(.SKP_INTERVAL(8), .SKP_CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tx_en_i      (tx_en_i),
    .os_req_i     (os_req_i),
    .os_type_i    (os_type_i),
    .link_num_i   (link_num_i),
    .lane_num_i   (lane_num_i),
    .n_fts_i      (n_fts_i),
    .rate_id_i    (rate_id_i),
    .train_ctrl_i (train_ctrl_i),
    .os_ack_o     (os_ack_o),
    .data_i       (data_i),
    .data_k_i     (data_k_i),
    .data_valid_i (data_valid_i),
    .data_last_i  (data_last_i),
    .data_ready_o (data_ready_o),
    .sym_o        (sym_o),
    .sym_k_o      (sym_k_o),
    .skp_sent_o   (skp_sent_o),
    .underrun_o   (underrun_o)
  );

  task automatic add(input logic r, input logic e, input logic o, input logic [1:0] t,
                     input logic [7:0] d, input logic dk, input logic v, input logic l,
                     input logic [7:0] s, input logic k, input logic a, input logic sk,
                     input logic u, input logic rd);
    vec_t x;
    x = '{r, e, o, t, d, dk, v, l, s, k, a, sk, u, rd};
    vecs.push_back(x);
  endtask

  task automatic quiet(input logic e, input int n);
    for (int i = 0; i < n; i++) add(1, e, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic skpSet(input logic o, input logic [1:0] t, input logic [7:0] d,
                        input logic v, input logic l);
    add(1, 1, o, t, d, 0, v, l, 8'hBC, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, o, t, d, 0, v, l, 8'h1C, 1, 0, 0, 0, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_ni       = v.rst_n;
    tx_en_i      = v.tx_en;
    os_req_i     = v.os_req;
    os_type_i    = v.os_type;
    data_i       = v.data;
    data_k_i     = v.data_k;
    data_valid_i = v.valid;
    data_last_i  = v.last;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                             input logic [7:0] exp);
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at vector %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] ts2Sym(input int i);
    case (i)
      0:       return 8'hBC;
      1:       return LINK;
      2:       return {3'b000, LANE};
      3:       return NFTS;
      4:       return RATE;
      5:       return CTRL;
      default: return 8'h45;
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       dk;
    int         waited;
    bit         seen;

    link_num_i = LINK; lane_num_i = LANE; n_fts_i = NFTS; rate_id_i = RATE; train_ctrl_i = CTRL;
    rst_ni = 0; tx_en_i = 1; os_req_i = 0; os_type_i = 0;
    data_i = 0; data_k_i = 0; data_valid_i = 0; data_last_i = 0;

    // Idle stream with periodic SKP after reset
    add(0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    quiet(1, 7);
    skpSet(0, 2'd0, 8'h00, 0, 0);
    quiet(1, 4);
    skpSet(0, 2'd0, 8'h00, 0, 0);
    quiet(0, 1);

    // TS1; SKP pending mid-set waits for the set's end
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, 8'hBC, 1, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, LINK, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, {3'b000, LANE}, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, NFTS, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, RATE, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, CTRL, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, 8'h4A, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2'd0, 8'h00, 0, 0, 0, 8'h4A, 0, 1, 0, 0, 0);
    skpSet(0, 2'd0, 8'h00, 0, 0);
    quiet(0, 1);

    // 20-byte packet with SKP pending from byte 6, then a held 1-byte packet
    quiet(1, 1);
    for (int i = 0; i < 20; i++) begin
      d  = (i == 0) ? 8'hFB : (i == 19) ? 8'hFD : 8'(8'h10 + i);
      dk = (i == 0) || (i == 19);
      add(1, 1, 0, 2'd0, d, dk, 1, (i == 19), d, dk, 0, 0, 0, 1);
    end
    skpSet(0, 2'd0, 8'hAA, 1, 1);
    add(1, 1, 0, 2'd0, 8'hAA, 0, 1, 1, 8'hAA, 0, 0, 0, 0, 1);
    quiet(1, 1);
    quiet(0, 1);

    // Two-cycle underrun mid-packet
    add(1, 1, 0, 2'd0, 8'hFB, 1, 1, 0, 8'hFB, 1, 0, 0, 0, 1);
    add(1, 1, 0, 2'd0, 8'h21, 0, 1, 0, 8'h21, 0, 0, 0, 0, 1);
    add(1, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 1, 0, 2'd0, 8'h22, 0, 1, 0, 8'h22, 0, 0, 0, 0, 1);
    add(1, 1, 0, 2'd0, 8'h23, 0, 1, 0, 8'h23, 0, 0, 0, 0, 1);
    add(1, 1, 0, 2'd0, 8'hFD, 1, 1, 1, 8'hFD, 1, 0, 0, 0, 1);
    skpSet(0, 2'd0, 8'h00, 0, 0);
    quiet(0, 1);

    // SKP, EIOS request and data all at one boundary; EIOS repeats back-to-back
    quiet(1, 7);
    skpSet(1, 2'd2, 8'hEE, 1, 1);
    add(1, 1, 1, 2'd2, 8'hEE, 0, 1, 1, 8'hBC, 1, 0, 0, 0, 0);
    add(1, 1, 1, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 0, 0, 0, 0);
    add(1, 1, 1, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 0, 0, 0, 0);
    add(1, 1, 1, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 1, 0, 0, 0);
    add(1, 1, 0, 2'd2, 8'hEE, 0, 1, 1, 8'hBC, 1, 0, 0, 0, 0);
    add(1, 1, 0, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 0, 0, 0, 0);
    add(1, 1, 0, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 0, 0, 0, 0);
    add(1, 1, 0, 2'd2, 8'hEE, 0, 1, 1, 8'h7C, 1, 0, 0, 0, 0);
    skpSet(0, 2'd2, 8'hEE, 1, 1);
    add(1, 1, 0, 2'd2, 8'hEE, 0, 1, 1, 8'hEE, 0, 0, 0, 0, 1);
    quiet(1, 1);
    quiet(0, 1);

    step();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_i);
      checkOutput("data_ready", i, 8'(data_ready_o), 8'(vecs[i].rdy));
      step();
      n_vectors++;
      checkOutput("sym", i, sym_o, vecs[i].sym);
      checkOutput("sym_k", i, 8'(sym_k_o), 8'(vecs[i].k));
      checkOutput("os_ack", i, 8'(os_ack_o), 8'(vecs[i].ack));
      checkOutput("skp_sent", i, 8'(skp_sent_o), 8'(vecs[i].skp));
      checkOutput("underrun", i, 8'(underrun_o), 8'(vecs[i].under));
    end

    // Reset in the middle of a TS2, then the SKP timer must restart from zero
    rst_ni = 1; tx_en_i = 1; os_req_i = 1; os_type_i = 2'd1;
    data_valid_i = 0; data_last_i = 0; data_k_i = 0; data_i = 8'h00;
    for (int i = 0; i < 9; i++) begin
      step();
      n_vectors++;
      checkOutput("ts2_sym", i, sym_o, ts2Sym(i));
      checkOutput("ts2_k", i, 8'(sym_k_o), (i == 0) ? 8'd1 : 8'd0);
    end
    rst_ni = 0; os_req_i = 0;
    step();
    n_vectors++;
    checkOutput("reset_sym", 0, sym_o, 8'h00);
    checkOutput("reset_k", 0, 8'(sym_k_o), 8'd0);
    checkOutput("reset_ack", 0, 8'(os_ack_o), 8'd0);
    rst_ni = 1;
    waited = 0;
    seen = 0;
    while (!seen && waited < 20) begin
      step();
      waited++;
      if (skp_sent_o) seen = 1;
      else checkOutput("post_reset_idle", waited, sym_o, 8'h00);
    end
    n_vectors++;
    checkOutput("skp_restart_cycles", 0, 8'(waited), 8'd8);
    checkOutput("skp_restart_sym", 0, sym_o, 8'hBC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
